img_out_streamer: RTL and testbench

IMG_OUT_STREAMER -- requirements
Module: img_out_streamer

---
 rtl/dsa_pkg.sv | 17 +
 rtl/pix_fifo.sv | 56 +++++
 rtl/img_out_streamer.sv | 142 ++++++++++++++
 tb/tb_img_out_streamer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsa_pkg.sv
// rtl/dsa_pkg.sv - shared types and constants for the output-image streamer
package dsa_pkg;

    localparam int PIX_W = 8;
    localparam int TAG_W = PIX_W + 2;

    typedef logic [15:0] dim_t;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        RUN,
        DRAIN,
        FIN
    } stream_state_t;

endpackage

// File: rtl/pix_fifo.sv
// rtl/pix_fifo.sv - small pixel FIFO with combinational head read
module pix_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 10
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            if (do_push && !do_pop)
                count <= count + CW'(1);
            else if (!do_push && do_pop)
                count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/img_out_streamer.sv
// rtl/img_out_streamer.sv - streams a w*h frame from output BRAM as a pixel stream
module img_out_streamer
    import dsa_pkg::*;
#(
    parameter int AW     = 12,
    parameter int FIFO_D = 2
) (
    input  logic             clk_50,
    input  logic             rst_n,
    input  logic             start,
    input  dim_t             out_w,
    input  dim_t             out_h,
    output logic             busy,
    output logic             done,
    output logic             err_size,
    output logic [AW-1:0]    mem_raddr,
    input  logic [PIX_W-1:0] mem_rdata,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [PIX_W-1:0] m_data,
    output logic             m_eol,
    output logic             m_last
);

    localparam int          CW      = $clog2(FIFO_D + 1);
    localparam logic [32:0] MAX_PIX = 33'd1 << AW;

    stream_state_t state, state_next;

    dim_t          w_q, h_q;
    dim_t          col, row;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] raddr_q;
    logic          inflight;
    logic          tag_eol, tag_last;

    logic [31:0]   total;
    logic          size_bad;
    logic          cur_eol, cur_last;
    logic          issue, pop, credit_ok;

    logic [TAG_W-1:0] fifo_head;
    logic             fifo_full, fifo_empty;
    logic [CW-1:0]    fifo_count;

    assign total    = 32'(w_q) * 32'(h_q);
    assign size_bad = (total == '0) || ({1'b0, total} > MAX_PIX);

    assign cur_eol  = (col == w_q - 16'd1);
    assign cur_last = cur_eol && (row == h_q - 16'd1);

    assign pop = m_valid && m_ready;

    // A slot freed by a same-cycle pop counts as free; without it a 2-deep
    // buffer could not sustain one pixel per cycle.
    assign credit_ok = (int'(fifo_count) + int'(inflight)) < (FIFO_D + int'(pop));
    assign issue     = (state == RUN) && credit_ok && (!fifo_full || pop);

    assign mem_raddr = issue ? rd_addr : raddr_q;

    assign m_valid = !fifo_empty;
    assign m_data  = m_valid ? fifo_head[PIX_W-1:0] : '0;
    assign m_eol   = m_valid && fifo_head[PIX_W];
    assign m_last  = m_valid && fifo_head[PIX_W+1];

    assign busy = (state == CHECK) || (state == RUN) || (state == DRAIN);
    assign done = (state == FIN);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CHECK;
            CHECK:   state_next = size_bad ? FIN : RUN;
            RUN:     if (issue && cur_last) state_next = DRAIN;
            DRAIN:   if (fifo_empty && !inflight) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            state    <= IDLE;
            w_q      <= '0;
            h_q      <= '0;
            col      <= '0;
            row      <= '0;
            rd_addr  <= '0;
            raddr_q  <= '0;
            inflight <= 1'b0;
            tag_eol  <= 1'b0;
            tag_last <= 1'b0;
            err_size <= 1'b0;
        end else begin
            state    <= state_next;
            inflight <= issue;

            if (state == IDLE && start) begin
                w_q      <= out_w;
                h_q      <= out_h;
                err_size <= 1'b0;
            end

            if (state == CHECK) begin
                rd_addr <= '0;
                col     <= '0;
                row     <= '0;
                if (size_bad) err_size <= 1'b1;
            end

            // Tags travel alongside the read so they land with its data.
            if (issue) begin
                raddr_q  <= rd_addr;
                rd_addr  <= rd_addr + AW'(1);
                tag_eol  <= cur_eol;
                tag_last <= cur_last;
                if (cur_eol) begin
                    col <= '0;
                    row <= row + 16'd1;
                end else begin
                    col <= col + 16'd1;
                end
            end
        end
    end

    pix_fifo #(
        .DEPTH (FIFO_D),
        .WIDTH (TAG_W)
    ) u_fifo (
        .clk   (clk_50),
        .rst_n (rst_n),
        .push  (inflight),
        .pop   (pop),
        .wdata ({tag_last, tag_eol, mem_rdata}),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_img_out_streamer.sv
// tb/tb_img_out_streamer.sv - scoreboard bench for img_out_streamer
module tb_img_out_streamer;
    import dsa_pkg::*;

    localparam int AW     = 12;
    localparam int FIFO_D = 2;

    logic          clk_50 = 1'b0;
    logic          rst_n;
    logic          start;
    dim_t          out_w, out_h;
    logic          busy, done, err_size;
    logic [AW-1:0] mem_raddr;
    logic [7:0]    mem_rdata = 8'h00;
    logic          m_valid, m_ready;
    logic [7:0]    m_data;
    logic          m_eol, m_last;

    typedef struct packed {
        logic [7:0] d;
        logic       eol;
        logic       last;
    } beat_t;

    beat_t exp_q[$];

    int tests = 0, fails = 0;
    int beats = 0, done_cnt = 0, valid_cyc = 0, run_len = 0, max_addr = 0;
    logic bp = 1'b0;

    always #10 clk_50 = ~clk_50;

    img_out_streamer #(.AW(AW), .FIFO_D(FIFO_D)) dut (
        .clk_50    (clk_50),
        .rst_n     (rst_n),
        .start     (start),
        .out_w     (out_w),
        .out_h     (out_h),
        .busy      (busy),
        .done      (done),
        .err_size  (err_size),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_eol     (m_eol),
        .m_last    (m_last)
    );

    function automatic logic [7:0] bram(input logic [AW-1:0] a);
        logic [7:0] hi;
        hi = 8'(a[11:8]) * 8'd37;
        return a[7:0] ^ hi;
    endfunction

    always @(posedge clk_50) mem_rdata <= bram(mem_raddr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin : monitor
        logic       stall_q;
        logic       beat_q;
        logic [9:0] stall_v;
        beat_t      e;
        stall_q = 1'b0;
        beat_q  = 1'b0;
        stall_v = '0;
        forever begin
            @(negedge clk_50);
            if (rst_n) begin
                if (stall_q) begin
                    chk("stall_valid", {31'd0, m_valid}, 32'd1);
                    chk("stall_data", {22'd0, m_last, m_eol, m_data}, {22'd0, stall_v});
                end
                if (m_valid) valid_cyc++;
                if (start && !busy) max_addr = 0;
                if (busy && int'(mem_raddr) > max_addr) max_addr = int'(mem_raddr);
                if (done) begin
                    done_cnt++;
                    chk("busy_at_done", {31'd0, busy}, 32'd0);
                end
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("sb_nonempty", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat", {22'd0, m_last, m_eol, m_data}, {22'd0, e.last, e.eol, e.d});
                    end
                    run_len = beat_q ? run_len + 1 : 1;
                    beats++;
                end
                beat_q  = m_valid && m_ready;
                stall_q = m_valid && !m_ready;
                stall_v = {m_last, m_eol, m_data};
            end else begin
                stall_q = 1'b0;
                beat_q  = 1'b0;
            end
        end
    end

    task automatic expect_frame(input int w, input int h);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                exp_q.push_back('{d: bram(AW'(r * w + c)), eol: (c == w - 1),
                                  last: (c == w - 1) && (r == h - 1)});
    endtask

    task automatic pulse_start(input int w, input int h);
        @(posedge clk_50); #1;
        out_w = dim_t'(w);
        out_h = dim_t'(h);
        start = 1'b1;
        @(posedge clk_50); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag, output int n);
        int d0;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            @(posedge clk_50); #1;
            n++;
            if (bp) m_ready = 1'($urandom_range(0, 1));
        end
        chk({tag, "_done_seen"}, 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_busy"},  {31'd0, busy},     32'd0);
        chk({tag, "_done"},  {31'd0, done},     32'd0);
        chk({tag, "_err"},   {31'd0, err_size}, 32'd0);
        chk({tag, "_valid"}, {31'd0, m_valid},  32'd0);
        chk({tag, "_data"},  {24'd0, m_data},   32'd0);
        chk({tag, "_eol"},   {31'd0, m_eol},    32'd0);
        chk({tag, "_last"},  {31'd0, m_last},   32'd0);
        chk({tag, "_raddr"}, 32'(mem_raddr),    32'd0);
    endtask

    initial begin : stim
        int n, k, b0, d0, v0;
        rst_n   = 1'b0;
        start   = 1'b0;
        out_w   = '0;
        out_h   = '0;
        m_ready = 1'b1;
        repeat (3) @(posedge clk_50);
        #1;
        check_reset("reset");
        rst_n = 1'b1;

        // 4x3 frame with latency and back-to-back throughput
        b0 = beats; d0 = done_cnt;
        expect_frame(4, 3);
        pulse_start(4, 3);
        k = 0;
        while (!m_valid && k < 10) begin
            @(posedge clk_50); #1;
            k++;
        end
        chk("first_valid_latency", 32'(k), 32'd3);
        wait_done(100, "frame", n);
        @(posedge clk_50); #1;
        chk("frame_beats", 32'(beats - b0), 32'd12);
        chk("frame_run_len", 32'(run_len), 32'd12);
        chk("frame_dones", 32'(done_cnt - d0), 32'd1);
        chk("frame_sb_empty", 32'(exp_q.size()), 32'd0);
        chk("frame_busy_after", {31'd0, busy}, 32'd0);

        // 8x2 frame under random backpressure
        b0 = beats; d0 = done_cnt;
        expect_frame(8, 2);
        bp = 1'b1;
        pulse_start(8, 2);
        wait_done(600, "bp", n);
        bp = 1'b0;
        m_ready = 1'b1;
        chk("bp_beats", 32'(beats - b0), 32'd16);
        chk("bp_dones", 32'(done_cnt - d0), 32'd1);
        chk("bp_sb_empty", 32'(exp_q.size()), 32'd0);

        // illegal sizes: zero area, then larger than the BRAM
        v0 = valid_cyc;
        pulse_start(0, 5);
        wait_done(3, "err_zero", n);
        chk("err_zero_latency_ok", {31'd0, (n <= 3)}, 32'd1);
        @(posedge clk_50); #1;
        chk("err_zero_flag", {31'd0, err_size}, 32'd1);
        pulse_start(128, 64);
        wait_done(3, "err_big", n);
        chk("err_big_latency_ok", {31'd0, (n <= 3)}, 32'd1);
        @(posedge clk_50); #1;
        chk("err_big_flag", {31'd0, err_size}, 32'd1);
        chk("err_no_valid", 32'(valid_cyc - v0), 32'd0);
        b0 = beats;
        expect_frame(2, 2);
        pulse_start(2, 2);
        chk("err_cleared", {31'd0, err_size}, 32'd0);
        wait_done(100, "after_err", n);
        chk("after_err_beats", 32'(beats - b0), 32'd4);

        // second start during RUN is ignored
        b0 = beats; d0 = done_cnt;
        expect_frame(4, 4);
        pulse_start(4, 4);
        k = 0;
        while (beats - b0 < 2 && k < 50) begin
            @(posedge clk_50); #1;
            k++;
        end
        pulse_start(2, 2);
        wait_done(200, "ign", n);
        repeat (6) @(posedge clk_50);
        #1;
        chk("ign_beats", 32'(beats - b0), 32'd16);
        chk("ign_dones", 32'(done_cnt - d0), 32'd1);
        chk("ign_sb_empty", 32'(exp_q.size()), 32'd0);

        // reset at pixel 5 of a 4x4 frame
        b0 = beats;
        expect_frame(4, 4);
        pulse_start(4, 4);
        k = 0;
        while (beats - b0 < 5 && k < 50) begin
            @(posedge clk_50); #1;
            k++;
        end
        rst_n = 1'b0;
        @(posedge clk_50); #1;
        check_reset("mid_reset");
        rst_n = 1'b1;
        exp_q.delete();
        d0 = done_cnt;
        repeat (5) @(posedge clk_50);
        #1;
        chk("mid_reset_no_done", 32'(done_cnt - d0), 32'd0);
        b0 = beats;
        expect_frame(4, 4);
        pulse_start(4, 4);
        wait_done(200, "restart", n);
        chk("restart_beats", 32'(beats - b0), 32'd16);
        chk("restart_sb_empty", 32'(exp_q.size()), 32'd0);

        // single pixel
        b0 = beats;
        expect_frame(1, 1);
        pulse_start(1, 1);
        wait_done(50, "one", n);
        chk("one_beats", 32'(beats - b0), 32'd1);

        // full memory, 64x64 == 2^AW
        b0 = beats; d0 = done_cnt;
        expect_frame(64, 64);
        pulse_start(64, 64);
        wait_done(5000, "full", n);
        chk("full_beats", 32'(beats - b0), 32'd4096);
        chk("full_max_addr", 32'(max_addr), 32'd4095);
        chk("full_dones", 32'(done_cnt - d0), 32'd1);
        chk("full_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
